// File: rtl/min_max_ctrl.sv
// Control front end for min_max_top: synchronises switches and buttons, edits the
// min/max/value registers through a small field FSM and generates the LED blink wave.
`timescale 1ns/1ps
module min_max_ctrl #(
   parameter int VALSIZE  = 4,
   parameter int OSC_HALF = 25_000_000
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [1:0]         mode_i,
   input  logic               sel_i,
   input  logic               inc_i,
   input  logic               dec_i,
   output logic [1:0]         com_o,
   output logic [VALSIZE-1:0] min_o,
   output logic [VALSIZE-1:0] max_o,
   output logic [VALSIZE-1:0] val_o,
   output logic               osc_o,
   output logic [1:0]         field_o
);

   localparam int                 CW       = $clog2(OSC_HALF + 1);
   localparam logic [CW-1:0]      CNT_LAST = CW'(OSC_HALF - 1);
   localparam logic [VALSIZE-1:0] VAL_TOP  = '1;

   typedef enum logic [1:0] {
      ST_MIN = 2'b00,
      ST_MAX = 2'b01,
      ST_VAL = 2'b10
   } state_t;

   // Bit layout of the conditioning pipeline: {mode[1:0], sel, inc, dec}
   logic [4:0] meta_reg;
   logic [4:0] sync_reg;
   logic [2:0] hist_reg;
   logic       sel_pulse;
   logic       inc_pulse;
   logic       dec_pulse;
   logic       edit_inc;
   logic       edit_dec;

   state_t             state_reg, state_next;
   logic [VALSIZE-1:0] min_reg, min_next;
   logic [VALSIZE-1:0] max_reg, max_next;
   logic [VALSIZE-1:0] val_reg, val_next;
   logic [1:0]         com_reg;
   logic [CW-1:0]      cnt_reg;
   logic               osc_reg;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_reg <= '0;
         sync_reg <= '0;
         hist_reg <= '0;
         com_reg  <= '0;
      end else begin
         meta_reg <= {mode_i, sel_i, inc_i, dec_i};
         sync_reg <= meta_reg;
         hist_reg <= sync_reg[2:0];
         com_reg  <= sync_reg[4:3];
      end
   end

   assign {sel_pulse, inc_pulse, dec_pulse} = sync_reg[2:0] & ~hist_reg;

   // Opposing pulses in the same cycle cancel each other out.
   assign edit_inc = inc_pulse & ~dec_pulse;
   assign edit_dec = dec_pulse & ~inc_pulse;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= ST_MIN;
         min_reg   <= '0;
         max_reg   <= VAL_TOP;
         val_reg   <= '0;
      end else begin
         state_reg <= state_next;
         min_reg   <= min_next;
         max_reg   <= max_next;
         val_reg   <= val_next;
      end
   end

   // Saturation is tested on the current value, so no update can ever wrap.
   always_comb begin
      state_next = state_reg;
      min_next   = min_reg;
      max_next   = max_reg;
      val_next   = val_reg;
      case (state_reg)
         ST_MIN: begin
            if (edit_inc && (min_reg < max_reg)) min_next = min_reg + 1'b1;
            if (edit_dec && (min_reg != '0))     min_next = min_reg - 1'b1;
            if (sel_pulse)                       state_next = ST_MAX;
         end
         ST_MAX: begin
            if (edit_inc && (max_reg != VAL_TOP)) max_next = max_reg + 1'b1;
            if (edit_dec && (max_reg > min_reg))  max_next = max_reg - 1'b1;
            if (sel_pulse)                        state_next = ST_VAL;
         end
         ST_VAL: begin
            if (edit_inc && (val_reg != VAL_TOP)) val_next = val_reg + 1'b1;
            if (edit_dec && (val_reg != '0))      val_next = val_reg - 1'b1;
            if (sel_pulse)                        state_next = ST_MIN;
         end
         default: state_next = ST_MIN;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_reg <= '0;
         osc_reg <= 1'b0;
      end else if (cnt_reg == CNT_LAST) begin
         cnt_reg <= '0;
         osc_reg <= ~osc_reg;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign com_o   = com_reg;
   assign min_o   = min_reg;
   assign max_o   = max_reg;
   assign val_o   = val_reg;
   assign osc_o   = osc_reg;
   assign field_o = state_reg;

endmodule

// File: tb/tb_min_max_ctrl.sv
// Directed bench for min_max_ctrl (VALSIZE=4, OSC_HALF=4): expected register states
// are queued by a reference model at each press and popped when the update lands.
`timescale 1ns/1ps
module tb_min_max_ctrl;

   logic       clk;
   logic       rst_ni;
   logic [1:0] mode_i;
   logic       sel_i, inc_i, dec_i;
   logic [1:0] com_o;
   logic [3:0] min_o, max_o, val_o;
   logic       osc_o;
   logic [1:0] field_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0] com;
      logic [3:0] mn;
      logic [3:0] mx;
      logic [3:0] vl;
      logic [1:0] fd;
   } exp_t;

   exp_t sb[$];

   // Reference model state
   logic [1:0] m_com, m_fd;
   logic [3:0] m_mn, m_mx, m_vl;

   wire [17:0] dut_pack = {com_o, min_o, max_o, val_o, field_o};

   min_max_ctrl #(.VALSIZE(4), .OSC_HALF(4)) dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .mode_i (mode_i),
      .sel_i  (sel_i),
      .inc_i  (inc_i),
      .dec_i  (dec_i),
      .com_o  (com_o),
      .min_o  (min_o),
      .max_o  (max_o),
      .val_o  (val_o),
      .osc_o  (osc_o),
      .field_o(field_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [17:0] pk(input exp_t e);
      return {e.com, e.mn, e.mx, e.vl, e.fd};
   endfunction

   function automatic exp_t model_now();
      exp_t e;
      e.com = m_com; e.mn = m_mn; e.mx = m_mx; e.vl = m_vl; e.fd = m_fd;
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One button transaction: buttons held ~5 cycles, update expected right after E2.
   task automatic press(input logic s, input logic i, input logic d, input string tag);
      exp_t old_e, e;
      old_e = model_now();
      @(negedge clk);
      sel_i = s; inc_i = i; dec_i = d;
      if (i && !d) begin
         case (m_fd)
            2'd0: if (m_mn < m_mx)   m_mn = m_mn + 4'd1;
            2'd1: if (m_mx < 4'd15)  m_mx = m_mx + 4'd1;
            default: if (m_vl < 4'd15) m_vl = m_vl + 4'd1;
         endcase
      end
      if (d && !i) begin
         case (m_fd)
            2'd0: if (m_mn > 4'd0)   m_mn = m_mn - 4'd1;
            2'd1: if (m_mx > m_mn)   m_mx = m_mx - 4'd1;
            default: if (m_vl > 4'd0) m_vl = m_vl - 4'd1;
         endcase
      end
      if (s) m_fd = (m_fd == 2'd2) ? 2'd0 : m_fd + 2'd1;
      sb.push_back(model_now());
      @(posedge clk);   // E0
      @(posedge clk);   // E1
      @(negedge clk);
      check({tag, "_before_e2"}, dut_pack, pk(old_e));
      @(posedge clk);   // E2
      #1;
      e = sb.pop_front();
      check({tag, "_after_e2"}, dut_pack, pk(e));
      repeat (2) @(posedge clk);
      @(negedge clk);
      sel_i = 1'b0; inc_i = 1'b0; dec_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_held"}, dut_pack, pk(e));
      $display("txn %s: com=%0d min=%0d max=%0d val=%0d field=%0d", tag,
               com_o, min_o, max_o, val_o, field_o);
   endtask

   initial begin
      int n;
      rst_ni = 1'b0;
      mode_i = 2'b00;
      sel_i = 1'b0; inc_i = 1'b0; dec_i = 1'b0;
      m_com = 2'b00; m_fd = 2'd0; m_mn = 4'd0; m_mx = 4'd15; m_vl = 4'd0;

      // Reset state and blink start
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_com", com_o, 2'b00);
      check("rst_min", min_o, 4'd0);
      check("rst_max", max_o, 4'd15);
      check("rst_val", val_o, 4'd0);
      check("rst_osc", osc_o, 1'b0);
      check("rst_field", field_o, 2'b00);
      rst_ni = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("osc_edge%0d", k), osc_o, (k >= 4 && k < 8) ? 1'b1 : 1'b0);
      end

      // Command path: three edges from the first sampling edge
      @(negedge clk);
      mode_i = 2'b10;
      m_com  = 2'b10;
      repeat (3) @(posedge clk);
      #1;
      check("com_follow", com_o, 2'b10);

      // Field cycling
      press(1, 0, 0, "sel_to_max");
      press(1, 0, 0, "sel_to_val");
      press(1, 0, 0, "sel_to_min");

      // Bring max down to 5, then exercise both saturations
      press(1, 0, 0, "sel_max");
      for (int k = 0; k < 10; k++) press(0, 0, 1, $sformatf("max_dec%0d", k));
      press(1, 0, 0, "sel_val");
      press(1, 0, 0, "sel_min");
      for (int k = 0; k < 7; k++) press(0, 1, 0, $sformatf("min_inc%0d", k));
      press(1, 0, 0, "sel_max2");
      for (int k = 0; k < 3; k++) press(0, 0, 1, $sformatf("max_dec_floor%0d", k));
      press(1, 0, 0, "sel_val2");
      press(1, 0, 0, "sel_min2");
      for (int k = 0; k < 6; k++) press(0, 0, 1, $sformatf("min_dec%0d", k));

      // Value field: saturate high and low
      press(1, 0, 0, "sel_max3");
      press(1, 0, 0, "sel_val3");
      for (int k = 0; k < 20; k++) press(0, 1, 0, $sformatf("val_inc%0d", k));
      for (int k = 0; k < 16; k++) press(0, 0, 1, $sformatf("val_dec%0d", k));
      for (int k = 0; k < 3; k++) press(0, 1, 0, $sformatf("val_up%0d", k));

      // Simultaneous events
      press(0, 1, 1, "inc_dec_same");
      press(1, 1, 0, "sel_inc_same");
      for (int k = 0; k < 4; k++) press(0, 1, 0, $sformatf("min_up%0d", k));

      // Asynchronous reset mid-period with osc high and min = 4
      n = 0;
      while (osc_o !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("osc_high_wait", osc_o, 1'b1);
      check("min_before_rst", min_o, 4'd4);
      #1;
      rst_ni = 1'b0;
      mode_i = 2'b11;
      #1;
      check("arst_com", com_o, 2'b00);
      check("arst_min", min_o, 4'd0);
      check("arst_max", max_o, 4'd15);
      check("arst_val", val_o, 4'd0);
      check("arst_osc", osc_o, 1'b0);
      check("arst_field", field_o, 2'b00);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_ni = 1'b1;
      @(posedge clk);
      #1;
      check("com_after_e0", com_o, 2'b00);
      repeat (2) @(posedge clk);
      #1;
      check("com_after_e2", com_o, 2'b11);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
